mult_div_unit: RTL and testbench

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

---
 rtl/mult_div_pkg.sv | 21 ++
 rtl/mult_div_sign_fix.sv | 18 +
 rtl/mult_div_unit.sv | 194 +++++++++++++++++++
 tb/tb_mult_div_unit.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_div_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mult_div_pkg
// Brief    : Operation and FSM state encodings shared by the multiply/divide unit.
// Revision : 1.0 - initial release
// ============================================================================
package mult_div_pkg;

    localparam logic [1:0] OP_MULTU = 2'b00;
    localparam logic [1:0] OP_MULT  = 2'b01;
    localparam logic [1:0] OP_DIVU  = 2'b10;
    localparam logic [1:0] OP_DIV   = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/mult_div_sign_fix.sv
`default_nettype none
// ============================================================================
// Module   : mult_div_sign_fix
// Brief    : Conditional two's-complement negation (absolute value / sign fix).
// Revision : 1.0 - initial release
// ============================================================================
module mult_div_sign_fix #(
    parameter int W = 32
) (
    input  logic [W-1:0] i_value,
    input  logic         i_negate,
    output logic [W-1:0] o_result
);

    assign o_result = i_negate ? (~i_value + W'(1)) : i_value;

endmodule
`default_nettype wire

// File: rtl/mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : mult_div_unit
// Brief    : Iterative HI/LO multiply/divide unit, one bit per cycle, N+1 cycle latency.
// Revision : 1.0 - initial release
// ============================================================================
module mult_div_unit
    import mult_div_pkg::*;
#(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic [N-1:0] operand_a,
    input  logic [N-1:0] operand_b,
    input  logic         hi_we,
    input  logic         lo_we,
    input  logic [N-1:0] write_data,
    output logic [N-1:0] hi,
    output logic [N-1:0] lo,
    output logic         busy,
    output logic         done
);

    localparam int               CNT_W       = $clog2(N + 1);
    localparam logic [CNT_W-1:0] c_last_step = CNT_W'(N - 1);

    state_t           r_state;
    state_t           w_next_state;
    logic             r_is_div;
    logic             r_neg_q;
    logic             r_neg_r;
    logic             r_div0;
    logic [N-1:0]     r_a_raw;
    logic [N-1:0]     r_b;
    logic [N-1:0]     r_ah;
    logic [N-1:0]     r_al;
    logic [N-1:0]     r_hi;
    logic [N-1:0]     r_lo;
    logic [CNT_W-1:0] r_cnt;
    logic             r_done;

    logic             w_signed;
    logic             w_is_div;
    logic             w_accept;
    logic [N-1:0]     w_mag_a;
    logic [N-1:0]     w_mag_b;
    logic [N:0]       w_sum;
    logic [N:0]       w_shift;
    logic             w_ge;
    logic [N-1:0]     w_diff;
    logic [2*N-1:0]   w_prod_fix;
    logic [N-1:0]     w_quo_fix;
    logic [N-1:0]     w_rem_fix;

    assign w_signed = (op == OP_MULT) || (op == OP_DIV);
    assign w_is_div = (op == OP_DIVU) || (op == OP_DIV);
    assign w_accept = (r_state == IDLE) && start;

    mult_div_sign_fix #(.W(N)) u_abs_a (
        .i_value  (operand_a),
        .i_negate (w_signed & operand_a[N-1]),
        .o_result (w_mag_a)
    );

    mult_div_sign_fix #(.W(N)) u_abs_b (
        .i_value  (operand_b),
        .i_negate (w_signed & operand_b[N-1]),
        .o_result (w_mag_b)
    );

    mult_div_sign_fix #(.W(2*N)) u_fix_prod (
        .i_value  ({r_ah, r_al}),
        .i_negate (r_neg_q),
        .o_result (w_prod_fix)
    );

    mult_div_sign_fix #(.W(N)) u_fix_quo (
        .i_value  (r_al),
        .i_negate (r_neg_q),
        .o_result (w_quo_fix)
    );

    mult_div_sign_fix #(.W(N)) u_fix_rem (
        .i_value  (r_ah),
        .i_negate (r_neg_r),
        .o_result (w_rem_fix)
    );

    // Multiply: {r_ah,r_al} shifts right, r_al holds the remaining multiplier bits.
    assign w_sum   = {1'b0, r_ah} + (r_al[0] ? {1'b0, r_b} : '0);
    // Divide: {r_ah,r_al} shifts left, r_ah is the partial remainder, r_al collects quotient bits.
    // A successful trial always leaves a difference below the divisor, so N bits suffice.
    assign w_shift = {r_ah, r_al[N-1]};
    assign w_ge    = w_shift >= {1'b0, r_b};
    assign w_diff  = w_shift[N-1:0] - r_b;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        busy         = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_next_state = CALC;
                end
            end
            CALC: begin
                busy = 1'b1;
                if (r_cnt == c_last_step) begin
                    w_next_state = FIX;
                end
            end
            FIX: begin
                busy         = 1'b1;
                w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_div0   <= 1'b0;
            r_a_raw  <= '0;
            r_b      <= '0;
            r_ah     <= '0;
            r_al     <= '0;
            r_cnt    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_is_div <= w_is_div;
                r_neg_q  <= w_signed & (operand_a[N-1] ^ operand_b[N-1]);
                r_neg_r  <= w_signed & operand_a[N-1];
                r_div0   <= w_is_div && (operand_b == '0);
                r_a_raw  <= operand_a;
                r_b      <= w_mag_b;
                r_ah     <= '0;
                r_al     <= w_mag_a;
                r_cnt    <= '0;
            end else if (r_state == CALC) begin
                r_cnt <= r_cnt + CNT_W'(1);
                if (r_is_div) begin
                    r_ah <= w_ge ? w_diff : w_shift[N-1:0];
                    r_al <= {r_al[N-2:0], w_ge};
                end else begin
                    r_ah <= w_sum[N:1];
                    r_al <= {w_sum[0], r_al[N-1:1]};
                end
            end else if (r_state == FIX) begin
                r_done <= 1'b1;
                if (!r_is_div) begin
                    {r_hi, r_lo} <= w_prod_fix;
                end else if (r_div0) begin
                    r_hi <= r_a_raw;
                    r_lo <= '1;
                end else begin
                    r_hi <= w_rem_fix;
                    r_lo <= w_quo_fix;
                end
            end else begin
                // Idle with no start: MTHI/MTLO writes land here only.
                if (hi_we) begin
                    r_hi <= write_data;
                end
                if (lo_we) begin
                    r_lo <= write_data;
                end
            end
        end
    end

    assign hi   = r_hi;
    assign lo   = r_lo;
    assign done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mult_div_unit
// Brief    : Self-checking bench: directed vector table, corner sequences, random ops vs model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mult_div_unit;

    localparam int N = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [1:0]   op;
    logic [N-1:0] operand_a;
    logic [N-1:0] operand_b;
    logic         hi_we;
    logic         lo_we;
    logic [N-1:0] write_data;
    logic [N-1:0] hi;
    logic [N-1:0] lo;
    logic         busy;
    logic         done;

    int total = 0;
    int bad   = 0;

    mult_div_unit #(.N(N)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .op         (op),
        .operand_a  (operand_a),
        .operand_b  (operand_b),
        .hi_we      (hi_we),
        .lo_we      (lo_we),
        .write_data (write_data),
        .hi         (hi),
        .lo         (lo),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] eh;
        logic [31:0] el;
        bit          intf;
        bit          wws;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference: plain wide arithmetic over the architectural rules.
    function automatic void model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] eh, output logic [31:0] el);
        logic [63:0] p;
        longint      q;
        longint      r;
        case (o)
            2'b00: begin
                p  = {32'b0, a} * {32'b0, b};
                eh = p[63:32];
                el = p[31:0];
            end
            2'b01: begin
                q  = longint'($signed(a)) * longint'($signed(b));
                p  = q;
                eh = p[63:32];
                el = p[31:0];
            end
            2'b10: begin
                if (b == 0) begin
                    eh = a;
                    el = '1;
                end else begin
                    eh = a % b;
                    el = a / b;
                end
            end
            default: begin
                if (b == 0) begin
                    eh = a;
                    el = '1;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    eh = 32'h0;
                    el = 32'h8000_0000;
                end else begin
                    q  = longint'($signed(a)) / longint'($signed(b));
                    r  = longint'($signed(a)) % longint'($signed(b));
                    p  = q;
                    el = p[31:0];
                    p  = r;
                    eh = p[31:0];
                end
            end
        endcase
    endfunction

    // Runs one operation; lat counts edges after acceptance until done is seen.
    task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input bit intf, input bit wws,
                         output logic [31:0] rh, output logic [31:0] rl,
                         output int lat, output int bcnt, output int holdbad, output logic done2);
        logic [31:0] pre_h;
        logic [31:0] pre_l;
        @(negedge clk);
        pre_h     = hi;
        pre_l     = lo;
        start     = 1'b1;
        op        = o;
        operand_a = a;
        operand_b = b;
        if (wws) begin
            hi_we      = 1'b1;
            lo_we      = 1'b1;
            write_data = 32'h5A5A_5A5A;
        end
        @(negedge clk);
        start   = 1'b0;
        hi_we   = 1'b0;
        lo_we   = 1'b0;
        lat     = 0;
        bcnt    = 0;
        holdbad = 0;
        while (!done && lat < 200) begin
            if (busy) bcnt++;
            if (hi !== pre_h || lo !== pre_l) holdbad++;
            if (intf && lat == 5) begin
                start      = 1'b1;
                op         = 2'b00;
                operand_a  = 32'd5;
                operand_b  = 32'd5;
                hi_we      = 1'b1;
                lo_we      = 1'b1;
                write_data = 32'hDEAD_BEEF;
            end else begin
                start = 1'b0;
                hi_we = 1'b0;
                lo_we = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        hi_we = 1'b0;
        lo_we = 1'b0;
        rh    = hi;
        rl    = lo;
        @(negedge clk);
        done2 = done;
        if (hi !== rh || lo !== rl) holdbad++;
    endtask

    initial begin
        logic [31:0] rh, rl, eh, el;
        int          lat, bcnt, holdbad, seen;
        logic        done2;

        vecs[0]  = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 1'b0};
        vecs[1]  = '{2'b01, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b1, 1'b0};
        vecs[2]  = '{2'b11, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 1'b0};
        vecs[3]  = '{2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, 1'b0};
        vecs[4]  = '{2'b10, 32'h0000_0064, 32'h0000_0000, 32'h0000_0064, 32'hFFFF_FFFF, 1'b0, 1'b0};
        vecs[5]  = '{2'b10, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E, 1'b0, 1'b1};
        vecs[6]  = '{2'b11, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0, 1'b0};
        vecs[7]  = '{2'b11, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0003, 1'b0, 1'b0};
        vecs[8]  = '{2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, 1'b0};
        vecs[9]  = '{2'b11, 32'h8000_0000, 32'h0000_0000, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0};
        vecs[10] = '{2'b00, 32'h0000_0000, 32'h0001_2345, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0};
        vecs[11] = '{2'b01, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0};

        reset      = 1'b0;
        start      = 1'b0;
        op         = 2'b00;
        operand_a  = '0;
        operand_b  = '0;
        hi_we      = 1'b0;
        lo_we      = 1'b0;
        write_data = '0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        chk("reset_hi", 64'(hi), 64'h0);
        chk("reset_lo", 64'(lo), 64'h0);
        chk("reset_busy", 64'(busy), 64'h0);
        chk("reset_done", 64'(done), 64'h0);

        // MTHI, then MTLO, then both together
        hi_we = 1'b1; write_data = 32'h1234_5678;
        @(negedge clk);
        hi_we = 1'b0;
        chk("mthi", 64'(hi), 64'h1234_5678);
        chk("mthi_lo_kept", 64'(lo), 64'h0);
        lo_we = 1'b1; write_data = 32'hCAFE_0001;
        @(negedge clk);
        lo_we = 1'b0;
        chk("mtlo", 64'(lo), 64'hCAFE_0001);
        chk("mtlo_hi_kept", 64'(hi), 64'h1234_5678);
        hi_we = 1'b1; lo_we = 1'b1; write_data = 32'h0BAD_F00D;
        @(negedge clk);
        hi_we = 1'b0; lo_we = 1'b0;
        chk("mt_both", {hi, lo}, {32'h0BAD_F00D, 32'h0BAD_F00D});

        for (int i = 0; i < 12; i++) begin
            do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].intf, vecs[i].wws,
                  rh, rl, lat, bcnt, holdbad, done2);
            chk($sformatf("vec%0d_hi", i), 64'(rh), 64'(vecs[i].eh));
            chk($sformatf("vec%0d_lo", i), 64'(rl), 64'(vecs[i].el));
            chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(N + 1));
            chk($sformatf("vec%0d_busy_cycles", i), 64'(bcnt), 64'(N + 1));
            chk($sformatf("vec%0d_hold", i), 64'(holdbad), 64'h0);
            chk($sformatf("vec%0d_done_pulse", i), 64'(done2), 64'h0);
        end

        // Reset mid-CALC aborts with no result and no done pulse
        hi_we = 1'b1; lo_we = 1'b1; write_data = 32'hAAAA_5555;
        @(negedge clk);
        hi_we = 1'b0; lo_we = 1'b0;
        start = 1'b1; op = 2'b00; operand_a = 32'd5; operand_b = 32'd5;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        chk("pre_abort_busy", 64'(busy), 64'h1);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        chk("abort_hi", 64'(hi), 64'h0);
        chk("abort_lo", 64'(lo), 64'h0);
        chk("abort_busy", 64'(busy), 64'h0);
        seen = 0;
        repeat (N + 5) begin
            @(negedge clk);
            if (done || busy) seen++;
        end
        chk("abort_no_done", 64'(seen), 64'h0);
        chk("abort_hi_after", 64'(hi), 64'h0);

        for (int i = 0; i < 40; i++) begin
            logic [1:0]  ro;
            logic [31:0] ra;
            logic [31:0] rb;
            int          mode;
            ro   = 2'($urandom_range(0, 3));
            ra   = $urandom;
            rb   = $urandom;
            mode = $urandom_range(0, 7);
            if (mode == 0) rb = 32'h0;
            else if (mode == 1) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
            else if (mode == 2) begin ra = 32'($urandom_range(0, 300)) - 32'd150; rb = 32'($urandom_range(0, 20)) - 32'd10; end
            model(ro, ra, rb, eh, el);
            do_op(ro, ra, rb, 1'b0, 1'b0, rh, rl, lat, bcnt, holdbad, done2);
            chk($sformatf("rnd%0d_op%0d_%h_%h", i, ro, ra, rb), {rh, rl}, {eh, el});
            chk($sformatf("rnd%0d_latency", i), 64'(lat), 64'(N + 1));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
